// File: rtl/instr_loader.sv
// Boot-time program loader: streams instruction words into instruction
// memory from address 0, kicks the CPU with a start pulse, then waits for done.
module instr_loader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int INSTR_WIDTH  = 9,
  parameter int START_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_req,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   im_wr_en,
  output logic [ADDR_WIDTH-1:0]  im_wr_addr,
  output logic [INSTR_WIDTH-1:0] im_wr_data,
  output logic                   cpu_start,
  input  logic                   cpu_done,
  output logic                   busy,
  output logic                   finished,
  output logic                   err,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic [15:0]            run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

  state_t                state;
  state_t                next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            start_cnt;
  logic                  accept;
  logic                  begin_load;

  assign in_ready  = (state == S_LOAD);
  assign cpu_start = (state == S_START);
  assign busy      = (state == S_LOAD) | (state == S_START) | (state == S_RUN);
  assign finished  = (state == S_DONE);
  assign err       = (state == S_ERROR);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next       = state;
    begin_load = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_req) begin
          next       = S_LOAD;
          begin_load = 1'b1;
        end
      end
      S_LOAD: begin
        // in_last outranks the overflow check on the final address
        if (accept && in_last)     next = S_START;
        else if (accept && &addr)  next = S_ERROR;
      end
      S_START: begin
        if (start_cnt == START_LAST) next = S_RUN;
      end
      S_RUN: begin
        if (cpu_done) next = S_DONE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      word_count <= '0;
      run_cycles <= '0;
      start_cnt  <= '0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
    end else begin
      im_wr_en <= accept;
      if (begin_load) begin
        addr       <= '0;
        word_count <= '0;
        run_cycles <= '0;
      end
      if (accept) begin
        im_wr_addr <= addr;
        im_wr_data <= in_data;
        addr       <= addr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (state == S_START) start_cnt <= start_cnt + 4'd1;
      else                  start_cnt <= '0;
      if (state == S_RUN && run_cycles != 16'hFFFF)
        run_cycles <= run_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a 12-bit-address instance for the main
// flow and a 3-bit-address instance sharing its inputs for overflow cases.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        cpu_done = 1'b0;

  logic        in_ready, im_wr_en, cpu_start, busy, finished, err;
  logic [11:0] im_wr_addr;
  logic [8:0]  im_wr_data;
  logic [12:0] word_count;
  logic [15:0] run_cycles;

  logic        s_in_ready, s_im_wr_en, s_cpu_start, s_busy, s_finished, s_err;
  logic [2:0]  s_im_wr_addr;
  logic [8:0]  s_im_wr_data;
  logic [3:0]  s_word_count;
  logic [15:0] s_run_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_WIDTH(12), .INSTR_WIDTH(9), .START_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
    .im_wr_data(im_wr_data), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .busy(busy), .finished(finished),
    .err(err), .word_count(word_count), .run_cycles(run_cycles)
  );

  instr_loader #(.ADDR_WIDTH(3), .INSTR_WIDTH(9), .START_CYCLES(2)) dut_s (
    .clk(clk), .reset(reset), .load_req(load_req),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last),
    .im_wr_en(s_im_wr_en), .im_wr_addr(s_im_wr_addr),
    .im_wr_data(s_im_wr_data), .cpu_start(s_cpu_start),
    .cpu_done(cpu_done), .busy(s_busy), .finished(s_finished),
    .err(s_err), .word_count(s_word_count), .run_cycles(s_run_cycles)
  );

  typedef struct {
    logic        load_req;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [8:0]  wr_data;
    logic        cpu_start;
    logic        busy;
    logic [12:0] word_count;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] big_or();
    return {31'd0, |{in_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_start,
                     busy, finished, err, word_count, run_cycles}};
  endfunction

  function automatic logic [31:0] small_or();
    return {31'd0, |{s_in_ready, s_im_wr_en, s_im_wr_addr, s_im_wr_data,
                     s_cpu_start, s_busy, s_finished, s_err, s_word_count,
                     s_run_cycles}};
  endfunction

  task automatic idle_inputs();
    load_req = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cpu_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1, 0, 9'h000, 0, 1, 0, 12'd0, 9'h000, 0, 1, 13'd0};
    vecs[1] = '{0, 1, 9'h1A5, 0, 1, 1, 12'd0, 9'h1A5, 0, 1, 13'd1};
    vecs[2] = '{0, 1, 9'h0FF, 0, 1, 1, 12'd1, 9'h0FF, 0, 1, 13'd2};
    vecs[3] = '{0, 1, 9'h100, 1, 0, 1, 12'd2, 9'h100, 1, 1, 13'd3};
    vecs[4] = '{0, 0, 9'h055, 0, 0, 0, 12'd2, 9'h100, 1, 1, 13'd3};
    vecs[5] = '{0, 0, 9'h000, 0, 0, 0, 12'd2, 9'h100, 0, 1, 13'd3};

    // reset held low while inputs toggle
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_req = i[0];
      in_valid = 1'b1;
      in_data  = 9'(i * 37);
      in_last  = i[1];
      cpu_done = ~i[0];
      tick();
      chk("rst_hold_big", big_or(), 0);
      chk("rst_hold_small", small_or(), 0);
    end
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_in_ready", {31'd0, in_ready}, 0);
      chk("idle_busy", {31'd0, busy}, 0);
    end

    // basic load, cycle by cycle
    foreach (vecs[i]) begin
      load_req = vecs[i].load_req;
      in_valid = vecs[i].in_valid;
      in_data  = vecs[i].in_data;
      in_last  = vecs[i].in_last;
      tick();
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].in_ready});
      chk($sformatf("v%0d_wr_en", i), {31'd0, im_wr_en}, {31'd0, vecs[i].wr_en});
      chk($sformatf("v%0d_wr_addr", i), {20'd0, im_wr_addr}, {20'd0, vecs[i].wr_addr});
      chk($sformatf("v%0d_wr_data", i), {23'd0, im_wr_data}, {23'd0, vecs[i].wr_data});
      chk($sformatf("v%0d_start", i), {31'd0, cpu_start}, {31'd0, vecs[i].cpu_start});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("v%0d_wcount", i), {19'd0, word_count}, {19'd0, vecs[i].word_count});
    end

    // run: done sampled on the 10th RUN cycle
    idle_inputs();
    for (int k = 1; k <= 10; k++) begin
      cpu_done = (k == 10);
      tick();
      chk($sformatf("run_cnt%0d", k), {16'd0, run_cycles}, k);
    end
    cpu_done = 1'b0;
    chk("run_finished", {31'd0, finished}, 1);
    chk("run_busy", {31'd0, busy}, 0);
    tick();
    chk("done_hold_cycles", {16'd0, run_cycles}, 10);
    chk("done_hold_wc", {19'd0, word_count}, 3);

    // reload from DONE
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("reload_finished", {31'd0, finished}, 0);
    chk("reload_wc", {19'd0, word_count}, 0);
    chk("reload_run", {16'd0, run_cycles}, 0);
    chk("reload_in_ready", {31'd0, in_ready}, 1);

    // gapped stream 1,0,0,1,1
    begin
      logic [4:0] pat;
      logic [8:0] dat [5];
      int         a;
      pat = 5'b11001;
      dat = '{9'h011, 9'h1FF, 9'h1EE, 9'h022, 9'h033};
      a = 0;
      for (int i = 0; i < 5; i++) begin
        in_valid = pat[i];
        in_data  = dat[i];
        in_last  = (i == 4);
        tick();
        chk($sformatf("gap%0d_wr_en", i), {31'd0, im_wr_en}, {31'd0, pat[i]});
        if (pat[i]) begin
          chk($sformatf("gap%0d_addr", i), {20'd0, im_wr_addr}, a);
          chk($sformatf("gap%0d_data", i), {23'd0, im_wr_data}, {23'd0, dat[i]});
          a++;
        end
      end
      idle_inputs();
      chk("gap_wc", {19'd0, word_count}, 3);
      chk("gap_start", {31'd0, cpu_start}, 1);
      tick();
      chk("gap_no_write", {31'd0, im_wr_en}, 0);
    end

    // finish this run on both instances
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("gap_done", {31'd0, finished}, 1);
    chk("gap_done_run", {16'd0, run_cycles}, 1);

    // overflow on the 3-bit instance
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 9'(9'h040 + i);
      in_last  = 1'b0;
      tick();
      chk($sformatf("ovf%0d_addr", i), {29'd0, s_im_wr_addr}, i);
      chk($sformatf("ovf%0d_en", i), {31'd0, s_im_wr_en}, 1);
    end
    idle_inputs();
    chk("ovf_err", {31'd0, s_err}, 1);
    chk("ovf_in_ready", {31'd0, s_in_ready}, 0);
    chk("ovf_wc", {28'd0, s_word_count}, 8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
      chk("ovf_no_start", {31'd0, s_cpu_start}, 0);
      chk("ovf_err_hold", {31'd0, s_err}, 1);
    end
    chk("ovf_no_write", {31'd0, s_im_wr_en}, 0);
    idle_inputs();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("ovf_clear_err", {31'd0, s_err}, 0);
    chk("ovf_reload", {31'd0, s_in_ready}, 1);

    // in_last on the final address wins over overflow
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 9'(9'h080 + i);
      in_last  = (i == 7);
      tick();
    end
    idle_inputs();
    chk("lastfin_start", {31'd0, s_cpu_start}, 1);
    chk("lastfin_err", {31'd0, s_err}, 0);
    chk("lastfin_addr", {29'd0, s_im_wr_addr}, 7);
    chk("lastfin_data", {23'd0, s_im_wr_data}, 32'h087);

    // async reset mid-RUN
    tick();
    tick();
    chk("pre_rst_run", {31'd0, busy & ~cpu_start}, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_run_big", big_or(), 0);
    chk("rst_run_small", small_or(), 0);
    tick();
    reset = 1'b1;
    cpu_done = 1'b1;
    tick();
    tick();
    cpu_done = 1'b0;
    chk("idle_done_ign", {31'd0, finished | busy | in_ready}, 0);
    chk("idle_done_run", {16'd0, run_cycles}, 0);

    // async reset mid-LOAD with a pending write
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'h123;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_wr", {31'd0, im_wr_en}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_load_big", big_or(), 0);
    chk("rst_load_small", small_or(), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
